// File: rtl/alu_seq.sv
// Sequential ALU: 1-cycle logic/arith ops, WIDTH-cycle shift-add MUL, N/Z flags qualified by a done strobe.
// Optional C/V flag outputs are enabled by defining ALU_CV_FLAGS_EN.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef ALU_CV_FLAGS_EN
  output logic             c,
  output logic             v,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             n,
  output logic             z
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] mcand, acc, acc_step;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   simple_res;
  logic               accept, is_mul, mul_last;

  assign accept   = start && (state != S_MUL);
  assign is_mul   = (op == 3'b110);
  assign mul_last = (state == S_MUL) && (cnt == CW'(1));
  assign acc_step = mplier[0] ? (acc + mcand) : acc;

  assign busy = (state == S_MUL);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nxt = is_mul ? S_MUL : S_DONE;
        else       state_nxt = S_IDLE;
      end
      S_MUL:   if (mul_last) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    simple_res = '0;
    case (op)
      3'b000:  simple_res = a + b;
      3'b001:  simple_res = a - b;
      3'b010:  simple_res = a & b;
      3'b011:  simple_res = a | b;
      3'b100:  simple_res = a ^ b;
      3'b101:  simple_res = ~a;
      3'b111:  simple_res = b;
      default: simple_res = '0;
    endcase
  end

`ifdef ALU_CV_FLAGS_EN
  logic [WIDTH:0] add_w, sub_w;
  logic           simple_c, simple_v;

  always_comb begin
    add_w    = {1'b0, a} + {1'b0, b};
    sub_w    = {1'b0, a} - {1'b0, b};
    simple_c = 1'b0;
    simple_v = 1'b0;
    case (op)
      3'b000: begin
        simple_c = add_w[WIDTH];
        simple_v = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001: begin
        // c is "no borrow", i.e. a >= b unsigned
        simple_c = ~sub_w[WIDTH];
        simple_v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      default: begin
        simple_c = 1'b0;
        simple_v = 1'b0;
      end
    endcase
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      result <= '0;
      n      <= 1'b0;
      z      <= 1'b0;
`ifdef ALU_CV_FLAGS_EN
      c      <= 1'b0;
      v      <= 1'b0;
`endif
    end else if (accept) begin
      if (is_mul) begin
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        cnt    <= CW'(WIDTH);
      end else begin
        result <= simple_res;
        n      <= simple_res[WIDTH-1];
        z      <= (simple_res == '0);
`ifdef ALU_CV_FLAGS_EN
        c      <= simple_c;
        v      <= simple_v;
`endif
      end
    end else if (state == S_MUL) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
      // the final partial product is folded in on the same edge that enters DONE
      if (mul_last) begin
        result <= acc_step[WIDTH-1:0];
        n      <= acc_step[WIDTH-1];
        z      <= (acc_step[WIDTH-1:0] == '0);
`ifdef ALU_CV_FLAGS_EN
        c      <= |acc_step[2*WIDTH-1:WIDTH];
        v      <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, n, z;
  logic [W-1:0] result;
`ifdef ALU_CV_FLAGS_EN
  logic         c, v;
`endif

  int pass_cnt = 0;
  int total = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
`ifdef ALU_CV_FLAGS_EN
    .c(c), .v(v),
`endif
    .busy(busy), .done(done), .result(result), .n(n), .z(z)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic c_e, output logic v_e);
    int m, hi, lo, sx, sy, full;
    m  = 1 << W;
    hi = m / 2 - 1;
    lo = -(m / 2);
    sx = (int'(x) > hi) ? int'(x) - m : int'(x);
    sy = (int'(y) > hi) ? int'(y) - m : int'(y);
    c_e = 1'b0;
    v_e = 1'b0;
    case (o)
      3'd0: begin
        full = int'(x) + int'(y);
        r = W'(full % m);
        c_e = (full >= m);
        v_e = (sx + sy > hi) || (sx + sy < lo);
      end
      3'd1: begin
        full = int'(x) - int'(y);
        r = W'((full + m) % m);
        c_e = (int'(x) >= int'(y));
        v_e = (sx - sy > hi) || (sx - sy < lo);
      end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = ~x;
      3'd6: begin
        full = int'(x) * int'(y);
        r = W'(full % m);
        c_e = (full >= m);
      end
      default: r = y;
    endcase
  endfunction

  // Issues one op and checks it through its done cycle; returns in the done cycle.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
    logic [W-1:0] er;
    logic ec, ev;
    int bad;
    model(o, x, y, er, ec, ev);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); op = 3'($urandom);
    if (o == 3'd6) begin
      bad = 0;
      for (int i = 0; i < W; i++) begin
        if (busy !== 1'b1 || done !== 1'b0) bad++;
        @(posedge clk); #1;
      end
      total++;
      if (bad != 0) $display("FAIL %s busy_window bad_cycles=%0d required=0", tag, bad);
      else pass_cnt++;
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0) $display("FAIL %s done/busy got %b/%b required 1/0", tag, done, busy);
    else pass_cnt++;
    total++;
    if (result !== er || n !== er[W-1] || z !== (er == '0))
      $display("FAIL %s result/n/z got %h/%b/%b required %h/%b/%b", tag, result, n, z, er, er[W-1], (er == '0));
    else pass_cnt++;
`ifdef ALU_CV_FLAGS_EN
    total++;
    if (c !== ec || v !== ev) $display("FAIL %s c/v got %b/%b required %b/%b", tag, c, v, ec, ev);
    else pass_cnt++;
`endif
  endtask

  task automatic idle_check(input string tag, input logic [W-1:0] held);
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== held)
      $display("FAIL %s idle done/busy/result got %b/%b/%h required 0/0/%h", tag, done, busy, result, held);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || n !== 1'b0 || z !== 1'b0)
      $display("FAIL reset outputs got busy=%b done=%b result=%h n=%b z=%b required all 0", busy, done, result, n, z);
    else pass_cnt++;
    rst_n = 1'b1;
    idle_check("reset_release", '0);
  endtask

  task automatic test_add_overflow();
    run_op(3'd0, 8'h7F, 8'h01, "add_7f_01");
    idle_check("add_after", 8'h80);
  endtask

  task automatic test_back_to_back();
    run_op(3'd1, 8'h05, 8'h05, "sub_eq");
    run_op(3'd3, 8'h0F, 8'hF0, "or_b2b");
    run_op(3'd6, 8'h03, 8'h07, "mul_b2b");
    run_op(3'd0, 8'hFF, 8'h01, "add_after_mul");
    idle_check("b2b_after", 8'h00);
  endtask

  task automatic test_mul();
    run_op(3'd6, 8'h0C, 8'h0B, "mul_0c_0b");
    idle_check("mul_after", 8'h84);
    run_op(3'd6, 8'h10, 8'h10, "mul_trunc");
    idle_check("mul_trunc_after", 8'h00);
    run_op(3'd6, 8'hFF, 8'hFF, "mul_ff_ff");
    idle_check("mul_ff_after", 8'h01);
  endtask

  task automatic test_start_ignored();
    int bad;
    int extra;
    start = 1'b1; op = 3'd6; a = 8'h0C; b = 8'h0B;
    @(posedge clk); #1;
    start = 1'b0;
    bad = 0;
    for (int i = 0; i < W; i++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      if (i == 2) begin start = 1'b1; op = 3'd0; a = 8'h01; b = 8'h01; end
      else start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    total++;
    if (bad != 0) $display("FAIL ignore busy_window bad_cycles=%0d required=0", bad);
    else pass_cnt++;
    total++;
    if (done !== 1'b1 || result !== 8'h84) $display("FAIL ignore done/result got %b/%h required 1/84", done, result);
    else pass_cnt++;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) extra++;
    end
    total++;
    if (extra != 0 || result !== 8'h84) $display("FAIL ignore extra_done count=%0d result=%h required 0/84", extra, result);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_mul();
    int extra;
    start = 1'b1; op = 3'd6; a = 8'hFF; b = 8'h03;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    total++;
    if (busy !== 1'b1) $display("FAIL rst_mid busy_before got %b required 1", busy);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || n !== 1'b0 || z !== 1'b0)
      $display("FAIL rst_mid outputs got busy=%b done=%b result=%h n=%b z=%b required all 0", busy, done, result, n, z);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 2 * W + 4; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0 || result !== '0) extra++;
    end
    total++;
    if (extra != 0) $display("FAIL rst_mid after_release bad_cycles=%0d required=0", extra);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [2:0]   o;
    logic [W-1:0] x, y, er;
    logic         ec, ev;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom);
      x = W'($urandom);
      y = W'($urandom_range(0, 3) == 0 ? 0 : $urandom);
      run_op(o, x, y, $sformatf("rand%0d_op%0d", i, o));
      if ($urandom_range(0, 1) == 1) begin
        model(o, x, y, er, ec, ev);
        idle_check($sformatf("rand%0d_idle", i), er);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_back_to_back();
    test_mul();
    test_start_ignored();
    test_reset_mid_mul();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
